// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble vectors, deferred flush
// ordering, saturating statistics and a consecutive-stall watchdog.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 5,
  parameter int LW         = $clog2(STAGES+1),
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [LW-1:0]     flush_lvl,
  input  logic              clr_stats,
  output logic [STAGES-1:0] stall_out,
  output logic [STAGES-1:0] bubble_out,
  output logic [STAGES-1:0] flush_out,
  output logic              flush_pend,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              wdog_err
);

  localparam int WD_W =
    (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT+1) : 1;
  localparam logic [WD_W-1:0] WDL = WD_W'(WDOG_LIMIT);
  localparam logic [LW-1:0] MAXL = LW'(STAGES);

  logic [LW-1:0]    r_pend_lvl;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [WD_W-1:0]  r_cons;
  logic             r_wdog;

  logic [LW-1:0] w_k;
  logic          w_any;
  logic [LW-1:0] w_req_lvl;
  logic [LW-1:0] w_eff;
  logic          w_go;
  logic          w_stalled;
  logic          w_flushed;

  always_comb begin
    w_k   = '0;
    w_any = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (stall_req[i]) begin
        w_k   = LW'(i);
        w_any = 1'b1;
      end
    end
  end

  // Out-of-range levels are clamped to a full flush.
  assign w_req_lvl = !flush_req ? '0 :
                     (flush_lvl > MAXL) ? MAXL : flush_lvl;
  assign w_eff = (r_pend_lvl > w_req_lvl) ? r_pend_lvl
                                          : w_req_lvl;
  assign w_go  = (w_eff != '0) && (!w_any || (w_k < w_eff));

  always_comb begin
    stall_out  = '0;
    bubble_out = '0;
    flush_out  = '0;
    if (!rst) begin
      if (!rdy) begin
        stall_out = '1;
      end else if (w_go) begin
        for (int i = 0; i < STAGES; i++)
          flush_out[i] = LW'(i) < w_eff;
      end else if (w_any) begin
        for (int i = 0; i < STAGES; i++) begin
          stall_out[i]  = LW'(i) <= w_k;
          bubble_out[i] = LW'(i) == (w_k + LW'(1));
        end
      end
    end
  end

  assign w_stalled = |stall_out;
  assign w_flushed = |flush_out;

  // w_eff already holds the merged level, so loading it merges.
  always_ff @(posedge clk) begin
    if (rst)
      r_pend_lvl <= '0;
    else if (rdy && w_go)
      r_pend_lvl <= '0;
    else
      r_pend_lvl <= w_eff;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_cons         <= '0;
      r_wdog         <= 1'b0;
    end else if (rdy) begin
      if (w_stalled && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flushed && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
      if (!w_stalled)
        r_cons <= '0;
      else if (r_cons != WDL)
        r_cons <= r_cons + WD_W'(1);
      if ((WDOG_LIMIT != 0) && w_stalled &&
          (r_cons >= WDL - WD_W'(1)))
        r_wdog <= 1'b1;
    end
  end

  assign flush_pend   = |r_pend_lvl;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign wdog_err     = r_wdog;

endmodule
